aha_code_region_arbiter: RTL

Two-requester arbiter for the code-region SRAM slave. It shares that slave between the CM3 merged I/D-code AHB-Lite bus and a word-wide valid/ready loader port (debug or boot image load). The CPU has priority. A starvation counter guarantees the loader one slot after `LD_MAX_WAIT` lost arbitrations. The block sits between the CPU integration level and the code-region slave, and issues non-overlapped single transfers downstream.

---
 rtl/aha_code_region_arbiter.sv | 101 ++++++++++
 1 files changed

// File: rtl/aha_code_region_arbiter.sv
// aha_code_region_arbiter: shares the code-region slave between the CPU code bus and a word loader
module aha_code_region_arbiter #(
  parameter int LD_MAX_WAIT = 8
) (
  input  logic        HCLK,
  input  logic        HRESET,
  input  logic [1:0]  S_HTRANS,
  input  logic [31:0] S_HADDR,
  input  logic [2:0]  S_HSIZE,
  input  logic        S_HWRITE,
  input  logic [31:0] S_HWDATA,
  output logic        S_HREADYOUT,
  output logic [1:0]  S_HRESP,
  output logic [31:0] S_HRDATA,
  input  logic        LD_VALID,
  input  logic        LD_WRITE,
  input  logic [31:0] LD_ADDR,
  input  logic [31:0] LD_WDATA,
  output logic        LD_READY,
  output logic        LD_DONE,
  output logic [31:0] LD_RDATA,
  output logic        LD_RESP,
  output logic [1:0]  M_HTRANS,
  output logic [31:0] M_HADDR,
  output logic [2:0]  M_HSIZE,
  output logic        M_HWRITE,
  output logic [31:0] M_HWDATA,
  output logic        M_HREADY,
  input  logic        M_HREADYOUT,
  input  logic [1:0]  M_HRESP,
  input  logic [31:0] M_HRDATA
);
  typedef enum logic [1:0] {IDLE, C_DP, L_DP} state_t;
  state_t state, state_nxt;
  logic        pend_valid;
  logic [31:0] pend_addr;
  logic [2:0]  pend_size;
  logic        pend_write;
  logic [7:0]  starve_cnt;
  logic [31:0] ld_wdata_q;
  logic        forced, cpu_win, ld_win, capture;
  logic        unused_bits;

  assign unused_bits = ^{S_HTRANS[0], LD_ADDR[1:0], M_HRESP[1]};
  assign forced   = LD_VALID && (starve_cnt == 8'(LD_MAX_WAIT));
  assign cpu_win  = (state == IDLE) && pend_valid && !forced;
  assign ld_win   = (state == IDLE) && !cpu_win && LD_VALID;
  assign capture  = S_HTRANS[1] && S_HREADYOUT;
  assign M_HREADY = M_HREADYOUT;

  // Bus outputs: the CPU stalls while a captured transfer is pending or its data phase is waited
  always_comb begin
    S_HREADYOUT = HRESET || ((state == C_DP) ? M_HREADYOUT : !pend_valid);
    S_HRESP     = (!HRESET && state == C_DP) ? M_HRESP : 2'b00;
    S_HRDATA    = (state == C_DP) ? M_HRDATA : 32'd0;
    M_HTRANS    = (!HRESET && (cpu_win || ld_win)) ? 2'b10 : 2'b00;
    M_HADDR     = cpu_win ? pend_addr : ld_win ? {LD_ADDR[31:2], 2'b00} : 32'd0;
    M_HSIZE     = cpu_win ? pend_size : ld_win ? 3'b010 : 3'b000;
    M_HWRITE    = cpu_win ? pend_write : (ld_win && LD_WRITE);
    M_HWDATA    = (state == C_DP) ? S_HWDATA : (state == L_DP) ? ld_wdata_q : 32'd0;
    LD_READY    = !HRESET && ld_win;
    LD_DONE     = !HRESET && (state == L_DP) && M_HREADYOUT;
    LD_RDATA    = LD_DONE ? M_HRDATA : 32'd0;
    LD_RESP     = LD_DONE && M_HRESP[0];
  end

  // Next state: grants leave IDLE, a ready data phase returns to it
  always_comb begin
    state_nxt = cpu_win ? C_DP : ld_win ? L_DP : (state != IDLE && M_HREADYOUT) ? IDLE : state;
  end

  // State register
  always_ff @(posedge HCLK) begin
    if (HRESET) state <= IDLE;
    else        state <= state_nxt;
  end

  // Pending CPU address phase, starvation counter and loader write data
  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      pend_valid <= 1'b0;
      pend_addr  <= 32'd0;
      pend_size  <= 3'd0;
      pend_write <= 1'b0;
      starve_cnt <= 8'd0;
      ld_wdata_q <= 32'd0;
    end else begin
      if (capture) begin
        pend_valid <= 1'b1;
        pend_addr  <= S_HADDR;
        pend_size  <= S_HSIZE;
        pend_write <= S_HWRITE;
      end else if (cpu_win) begin
        pend_valid <= 1'b0;
      end
      if (!LD_VALID || ld_win) starve_cnt <= 8'd0;
      else if (cpu_win && starve_cnt != 8'(LD_MAX_WAIT)) starve_cnt <= starve_cnt + 8'd1;
      if (ld_win) ld_wdata_q <= LD_WDATA;
    end
  end
endmodule
